wf_rr_grant_picker: RTL and testbench
=====================================

Name: wf_rr_grant_picker

Overview:
- Registered round-robin arbiter that picks one wavefront slot out of NUM_REQ request lines each cycle.
- Sits directly upstream of the parameterised one-hot enable decoder in the issue path.
- grant_id drives the decoder's binary select; grant_valid drives its enable. The decoded one-hot then marks the selected wavefront slot.
- Holds its grant while the consumer stalls and rotates priority so that no slot starves.

Parameters:
- NUM_REQ, 40, number of request lines (wavefront slots); 2 <= NUM_REQ <= 2^ID_BITS.
- ID_BITS, 6, width of the binary grant index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  NUM_REQ  per-slot request; bit i high means slot i wants issue.
- grant_stall  input  1  downstream not ready; while high, a valid grant is held.
- grant_valid  output  1  registered; grant_id is meaningful (feeds decoder enable).
- grant_id  output  ID_BITS  registered binary index of the granted slot (feeds decoder select).
- last_ptr  output  ID_BITS  registered priority pointer (id of the most recent grant issued); for debug and verification.

Behaviour:
- Reset (rst high at a rising edge, which overrides all other inputs):
  - grant_valid=0, grant_id=0, last_ptr=NUM_REQ-1.
  - The first search after reset therefore starts at slot 0.
- Hold: if grant_valid=1 and grant_stall=1, all registers keep their values.
  - Sticky: the grant remains valid even if req[grant_id] deasserts during the stall.
- Pick: otherwise (grant_valid=0, or grant_stall=0):
  - Search req starting at (last_ptr+1) mod NUM_REQ, ascending with wrap-around past NUM_REQ-1 to 0, ending at last_ptr inclusive.
  - The first set bit found is idx.
  - Found: grant_valid<=1, grant_id<=idx, last_ptr<=idx.
  - None found: grant_valid<=0; grant_id and last_ptr hold their values.
- grant_stall is ignored when grant_valid=0.
- Latency: one cycle from req sampled to grant registered. A consumer that does not stall can see a new grant every cycle.
- Self-repeat: if only slot k requests, k is granted again every unstalled cycle, because the search includes last_ptr itself as the last candidate.
- Fairness: with S slots continuously requesting, each is granted exactly once in every S consecutive accepted grants.
- Wrap arithmetic: the pointer increment compares against NUM_REQ-1, not against 2^ID_BITS-1. Ids >= NUM_REQ are never produced.
- Upper bits of grant_id are zero-extended. Unused decoder outputs (when NUM_REQ < 2^ID_BITS) therefore never fire.
- Implementation guidance:
  - Fully synchronous; no combinational path from req to outputs.
  - Search implemented as a rotate / priority-encode / unrotate, or as a doubled request vector with a mask.

Test Plan:
1. Reset then rotation: rst high 2 cycles, then req=all ones, stall=0 -> after reset valid=0, id=0, last_ptr=39; then grants 0,1,2,...,39,0 on consecutive cycles.
2. Sparse requests: req bits 3 and 5 held, stall=0 -> grant_id sequence 3,5,3,5; valid stays 1 throughout.
3. Stall hold: grant id=5 valid, stall high 3 cycles, req[5] dropped in the first stall cycle, req[7] high -> id=5, valid=1 for all 3 cycles; first unstalled pick gives id=7.
4. Wrap: req bits 39 and 0 only, last_ptr=38 -> grants 39, then 0, then 39.
5. Idle: req=0 after a grant of id=12 -> next cycle valid=0, id=12, last_ptr=12; req[12] reasserted alone -> grant 12.
6. Reset mid-stall: valid grant id=20 with stall=1, rst pulsed 1 cycle -> valid=0, id=0, last_ptr=39; then req=all ones, stall=0 -> grant 0.

Source files
------------

// File: rtl/wf_rr_grant_picker_if.sv
// Request/grant bundle between wavefront slots and the round-robin grant picker.
// The picker sits on the slave side; the requester and stall source sit on the master side.
interface wf_rr_grant_picker_if #(
  parameter int NUM_REQ = 40,
  parameter int ID_BITS = 6
);
  logic [NUM_REQ-1:0] req;
  logic               grant_stall;
  logic               grant_valid;
  logic [ID_BITS-1:0] grant_id;
  logic [ID_BITS-1:0] last_ptr;

  modport master (
    output req,
    output grant_stall,
    input  grant_valid,
    input  grant_id,
    input  last_ptr
  );

  modport slave (
    input  req,
    input  grant_stall,
    output grant_valid,
    output grant_id,
    output last_ptr
  );
endinterface

// File: rtl/wf_rr_grant_picker.sv
// Registered round-robin arbiter selecting one wavefront slot per cycle; the grant is
// held while the consumer stalls and priority rotates past the most recent grant.
module wf_rr_grant_picker #(
  parameter int NUM_REQ = 40,
  parameter int ID_BITS = 6
) (
  input logic                 clk,
  input logic                 rst,
  wf_rr_grant_picker_if.slave bus
);

  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_REQ - 1);

  logic               grant_valid_q;
  logic [ID_BITS-1:0] grant_id_q;
  logic [ID_BITS-1:0] last_ptr_q;

  logic [NUM_REQ-1:0] hi_req;
  logic               hi_found;
  logic [ID_BITS-1:0] hi_idx;
  logic [ID_BITS-1:0] lo_idx;
  logic               found;
  logic [ID_BITS-1:0] idx;

  // Two-pass search: slots strictly above last_ptr first, then the whole vector from 0,
  // which wraps around and ends with last_ptr itself as the final candidate.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    hi_req   = '0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_req[i] = bus.req[i] && (ID_BITS'(i) > last_ptr_q);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hi_req[i]) begin
        hi_found = 1'b1;
        hi_idx   = ID_BITS'(i);
      end
      if (bus.req[i]) begin
        lo_idx = ID_BITS'(i);
      end
    end
    found = |bus.req;
    idx   = hi_found ? hi_idx : lo_idx;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_ptr_q    <= LAST_ID;
    end else if (!(grant_valid_q && bus.grant_stall)) begin
      if (found) begin
        grant_valid_q <= 1'b1;
        grant_id_q    <= idx;
        last_ptr_q    <= idx;
      end else begin
        grant_valid_q <= 1'b0;
      end
    end
  end

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.last_ptr    = last_ptr_q;

endmodule

// File: tb/tb_wf_rr_grant_picker.sv
// Self-checking bench for wf_rr_grant_picker: directed scenarios plus randomized
// requests/stalls compared against a set-based round-robin reference model.
module tb_wf_rr_grant_picker;

  localparam int NUM_REQ = 40;
  localparam int ID_BITS = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wf_rr_grant_picker_if #(.NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)) bus ();

  wf_rr_grant_picker #(.NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic exp_valid;
  int   exp_id;
  int   exp_ptr;

  // Next grant: lowest requesting id above the pointer, otherwise the lowest
  // requesting id overall (covers wrap-around and re-granting the pointer itself).
  function automatic int pick(logic [NUM_REQ-1:0] r, int ptr);
    for (int i = 0; i < NUM_REQ; i++)
      if (r[i] && i > ptr) return i;
    for (int i = 0; i < NUM_REQ; i++)
      if (r[i]) return i;
    return -1;
  endfunction

  // Advance the model by one rising edge with the currently driven inputs, then
  // move to a sampling point 1 time unit after the edge.
  task automatic step();
    int p;
    if (rst) begin
      exp_valid = 1'b0;
      exp_id    = 0;
      exp_ptr   = NUM_REQ - 1;
    end else if (!(exp_valid && bus.grant_stall)) begin
      p = pick(bus.req, exp_ptr);
      if (p >= 0) begin
        exp_valid = 1'b1;
        exp_id    = p;
        exp_ptr   = p;
      end else begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '1;
    bus.grant_stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_id !== '0 || bus.last_ptr !== ID_BITS'(NUM_REQ - 1)) begin
        errors++;
        $display("FAIL reset cyc%0d: got valid=%0b id=%0d ptr=%0d, want valid=0 id=0 ptr=%0d",
                 c, bus.grant_valid, bus.grant_id, bus.last_ptr, NUM_REQ - 1);
      end
    end
  endtask

  task automatic test_rotation();
    rst = 1'b0;
    bus.req = '1;
    bus.grant_stall = 1'b0;
    for (int c = 0; c <= NUM_REQ; c++) begin
      step();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_BITS'(c % NUM_REQ)
          || bus.last_ptr !== ID_BITS'(c % NUM_REQ)) begin
        errors++;
        $display("FAIL rotation cyc%0d: got valid=%0b id=%0d ptr=%0d, want valid=1 id=%0d",
                 c, bus.grant_valid, bus.grant_id, bus.last_ptr, c % NUM_REQ);
      end
    end
  endtask

  task automatic test_sparse();
    int want[4] = '{3, 5, 3, 5};
    bus.req = '0;
    bus.req[3] = 1'b1;
    bus.req[5] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_BITS'(want[c])) begin
        errors++;
        $display("FAIL sparse cyc%0d: got valid=%0b id=%0d, want valid=1 id=%0d",
                 c, bus.grant_valid, bus.grant_id, want[c]);
      end
    end
  endtask

  task automatic test_stall_hold();
    // Grant 5 is valid on entry; stall with req[5] dropped and req[7] raised.
    bus.req = '0;
    bus.req[7] = 1'b1;
    bus.grant_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_BITS'(5) || bus.last_ptr !== ID_BITS'(5)) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got valid=%0b id=%0d ptr=%0d, want valid=1 id=5 ptr=5",
                 c, bus.grant_valid, bus.grant_id, bus.last_ptr);
      end
    end
    bus.grant_stall = 1'b0;
    step();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_BITS'(7)) begin
      errors++;
      $display("FAIL stall_release: got valid=%0b id=%0d, want valid=1 id=7",
               bus.grant_valid, bus.grant_id);
    end
  endtask

  task automatic test_wrap();
    int want[3] = '{39, 0, 39};
    bus.req = '0;
    bus.req[38] = 1'b1;
    step();
    checks++;
    if (bus.last_ptr !== ID_BITS'(38)) begin
      errors++;
      $display("FAIL wrap_setup: got ptr=%0d, want 38", bus.last_ptr);
    end
    bus.req = '0;
    bus.req[39] = 1'b1;
    bus.req[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_BITS'(want[c])) begin
        errors++;
        $display("FAIL wrap cyc%0d: got valid=%0b id=%0d, want valid=1 id=%0d",
                 c, bus.grant_valid, bus.grant_id, want[c]);
      end
    end
  endtask

  task automatic test_idle();
    bus.req = '0;
    bus.req[12] = 1'b1;
    step();
    bus.req = '0;
    step();
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant_id !== ID_BITS'(12) || bus.last_ptr !== ID_BITS'(12)) begin
      errors++;
      $display("FAIL idle: got valid=%0b id=%0d ptr=%0d, want valid=0 id=12 ptr=12",
               bus.grant_valid, bus.grant_id, bus.last_ptr);
    end
    // Stall is ignored while no grant is valid.
    bus.grant_stall = 1'b1;
    bus.req[12] = 1'b1;
    step();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_BITS'(12)) begin
      errors++;
      $display("FAIL idle_regrant: got valid=%0b id=%0d, want valid=1 id=12",
               bus.grant_valid, bus.grant_id);
    end
    bus.grant_stall = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    bus.req = '0;
    bus.req[20] = 1'b1;
    step();
    bus.grant_stall = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant_id !== '0 || bus.last_ptr !== ID_BITS'(NUM_REQ - 1)) begin
      errors++;
      $display("FAIL reset_mid_stall: got valid=%0b id=%0d ptr=%0d, want valid=0 id=0 ptr=%0d",
               bus.grant_valid, bus.grant_id, bus.last_ptr, NUM_REQ - 1);
    end
    rst = 1'b0;
    bus.req = '1;
    bus.grant_stall = 1'b0;
    step();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall_regrant: got valid=%0b id=%0d, want valid=1 id=0",
               bus.grant_valid, bus.grant_id);
    end
  endtask

  task automatic test_random();
    int density;
    for (int c = 0; c < 600; c++) begin
      density = (c % 100 < 50) ? 8 : 60;
      for (int i = 0; i < NUM_REQ; i++)
        bus.req[i] = ($urandom_range(0, 99) < density);
      if ($urandom_range(0, 9) == 0) bus.req = '0;
      bus.grant_stall = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if (bus.grant_valid !== exp_valid || bus.grant_id !== ID_BITS'(exp_id)
          || bus.last_ptr !== ID_BITS'(exp_ptr)) begin
        errors++;
        $display("FAIL random cyc%0d: got valid=%0b id=%0d ptr=%0d, want valid=%0b id=%0d ptr=%0d",
                 c, bus.grant_valid, bus.grant_id, bus.last_ptr, exp_valid, exp_id, exp_ptr);
      end
    end
    bus.grant_stall = 1'b0;
  endtask

  task automatic test_fairness();
    // A fixed random subset requests continuously; every member must be granted
    // exactly once per window of S accepted grants.
    logic [NUM_REQ-1:0] set;
    int s;
    int cnt[NUM_REQ];
    set = '0;
    for (int i = 0; i < NUM_REQ; i++) set[i] = $urandom_range(0, 2) == 0;
    set[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
    s = $countones(set);
    bus.req = set;
    bus.grant_stall = 1'b0;
    step();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
      for (int g = 0; g < s; g++) begin
        if (bus.grant_valid === 1'b1 && int'(bus.grant_id) < NUM_REQ) cnt[bus.grant_id]++;
        step();
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        checks++;
        if (cnt[i] !== (set[i] ? 1 : 0)) begin
          errors++;
          $display("FAIL fairness win%0d slot%0d: got %0d grants, want %0d",
                   w, i, cnt[i], set[i] ? 1 : 0);
        end
      end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.grant_stall = 1'b0;
    exp_valid = 1'b0;
    exp_id = 0;
    exp_ptr = NUM_REQ - 1;
    test_reset();
    test_rotation();
    test_sparse();
    test_stall_hold();
    test_wrap();
    test_idle();
    test_reset_mid_stall();
    test_random();
    test_fairness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
